// File: rtl/lab_buffer_scheduler.sv
// LAB buffer scheduler: tracks four analog buffers through trigger, digitize and
// readout, and round-robins the single digitizer among buffers awaiting conversion.
module lab_buffer_scheduler #(
    parameter int DIG_TIMEOUT = 4096
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        trig_i,
    input  logic [1:0]  trig_buf_i,
    input  logic [31:0] trig_id_i,
    input  logic [3:0]  dig_req_i,
    output logic [3:0]  dig_start_o,
    input  logic        dig_done_i,
    output logic        dig_busy_o,
    output logic        rd_valid_o,
    output logic [1:0]  rd_buf_o,
    output logic [31:0] rd_id_o,
    input  logic        rd_release_i,
    output logic [7:0]  buf_state_o,
    output logic        full_o,
    output logic        trig_ovf_o,
    output logic        dig_timeout_o,
    input  logic        clr_err_i
);
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] HELD   = 2'd1;
    localparam logic [1:0] QUEUED = 2'd2;
    localparam logic [1:0] READY  = 2'd3;

    typedef enum logic [1:0] {D_IDLE, D_START, D_WAIT} dig_state_t;

    logic [3:0][1:0]  st, st_nxt;
    logic [3:0][31:0] ids;
    logic [3:0][1:0]  fifo;
    logic [1:0]       wr_ptr, rd_ptr, head;
    logic [2:0]       cnt;
    logic             trig_ok, push, pop;

    dig_state_t       dstate, dstate_nxt;
    logic [1:0]       cur_buf, cur_nxt, last_gnt, last_nxt, pick;
    logic [15:0]      tmo_cnt, tmo_nxt;
    logic             found, conv_done, tmo_hit;

    assign head       = fifo[rd_ptr];
    assign rd_valid_o = (cnt != 3'd0) && (st[head] == READY);
    assign rd_buf_o   = head;
    assign rd_id_o    = ids[head];
    assign full_o     = (st[0] != FREE) && (st[1] != FREE) &&
                        (st[2] != FREE) && (st[3] != FREE);
    assign buf_state_o = st;

    assign trig_ok = trig_i && (st[trig_buf_i] == FREE);
    assign push    = trig_ok;
    assign pop     = rd_release_i && rd_valid_o;

    // Round-robin scan starts one past the last grant; k=4 wraps back to it.
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && st[last_gnt + 2'(k)] == QUEUED) begin
                found = 1'b1;
                pick  = last_gnt + 2'(k);
            end
        end
    end

    always_comb begin
        dstate_nxt = dstate;
        cur_nxt    = cur_buf;
        last_nxt   = last_gnt;
        tmo_nxt    = tmo_cnt;
        conv_done  = 1'b0;
        tmo_hit    = 1'b0;
        case (dstate)
            D_IDLE: begin
                if (found) begin
                    cur_nxt    = pick;
                    last_nxt   = pick;
                    dstate_nxt = D_START;
                end
            end
            D_START: begin
                tmo_nxt    = 16'd0;
                dstate_nxt = D_WAIT;
            end
            D_WAIT: begin
                if (dig_done_i) begin
                    conv_done  = 1'b1;
                    dstate_nxt = D_IDLE;
                end else if (tmo_cnt == 16'(DIG_TIMEOUT - 1)) begin
                    conv_done  = 1'b1;
                    tmo_hit    = 1'b1;
                    dstate_nxt = D_IDLE;
                end else begin
                    tmo_nxt = tmo_cnt + 16'd1;
                end
            end
            default: dstate_nxt = D_IDLE;
        endcase
    end

    // Each event only applies to one source state, so they never collide per buffer.
    always_comb begin
        st_nxt = st;
        for (int n = 0; n < 4; n++) begin
            case (st[n])
                FREE:   if (trig_i && trig_buf_i == 2'(n)) st_nxt[n] = HELD;
                HELD:   if (dig_req_i[n]) st_nxt[n] = QUEUED;
                QUEUED: if (conv_done && cur_buf == 2'(n)) st_nxt[n] = READY;
                READY:  if (pop && head == 2'(n)) st_nxt[n] = FREE;
                default: st_nxt[n] = FREE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            st            <= '0;
            ids           <= '0;
            fifo          <= '0;
            wr_ptr        <= 2'd0;
            rd_ptr        <= 2'd0;
            cnt           <= 3'd0;
            dstate        <= D_IDLE;
            cur_buf       <= 2'd0;
            last_gnt      <= 2'd3;
            tmo_cnt       <= 16'd0;
            dig_start_o   <= 4'd0;
            dig_busy_o    <= 1'b0;
            trig_ovf_o    <= 1'b0;
            dig_timeout_o <= 1'b0;
        end else begin
            st       <= st_nxt;
            dstate   <= dstate_nxt;
            cur_buf  <= cur_nxt;
            last_gnt <= last_nxt;
            tmo_cnt  <= tmo_nxt;
            if (push) begin
                ids[trig_buf_i] <= trig_id_i;
                fifo[wr_ptr]    <= trig_buf_i;
                wr_ptr          <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            cnt <= cnt + {2'b0, push} - {2'b0, pop};
            dig_start_o <= 4'd0;
            if (dstate == D_START) dig_start_o[cur_buf] <= 1'b1;
            dig_busy_o    <= (dstate_nxt != D_IDLE);
            trig_ovf_o    <= (trig_ovf_o & ~clr_err_i) | (trig_i & ~trig_ok);
            dig_timeout_o <= (dig_timeout_o & ~clr_err_i) | tmo_hit;
        end
    end
endmodule

// File: tb/tb_lab_buffer_scheduler.sv
// Self-checking bench for lab_buffer_scheduler: vector table plus scenario
// sequences, with scoreboards for start pulses and readout order.
module tb_lab_buffer_scheduler;
    logic        clk_i = 1'b0;
    logic        nrst_i;
    logic        trig_i;
    logic [1:0]  trig_buf_i;
    logic [31:0] trig_id_i;
    logic [3:0]  dig_req_i;
    logic        dig_done_i;
    logic        rd_release_i;
    logic        clr_err_i;

    logic [3:0]  dig_start_o, t_dig_start;
    logic        dig_busy_o, t_dig_busy;
    logic        rd_valid_o, t_rd_valid;
    logic [1:0]  rd_buf_o, t_rd_buf;
    logic [31:0] rd_id_o, t_rd_id;
    logic [7:0]  buf_state_o, t_buf_state;
    logic        full_o, t_full;
    logic        trig_ovf_o, t_trig_ovf;
    logic        dig_timeout_o, t_dig_timeout;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b1;
    int start_q[$];
    logic [31:0] rd_q[$];

    always #5 clk_i = ~clk_i;

    lab_buffer_scheduler dut (
        .clk_i(clk_i), .nrst_i(nrst_i), .trig_i(trig_i), .trig_buf_i(trig_buf_i),
        .trig_id_i(trig_id_i), .dig_req_i(dig_req_i), .dig_start_o(dig_start_o),
        .dig_done_i(dig_done_i), .dig_busy_o(dig_busy_o), .rd_valid_o(rd_valid_o),
        .rd_buf_o(rd_buf_o), .rd_id_o(rd_id_o), .rd_release_i(rd_release_i),
        .buf_state_o(buf_state_o), .full_o(full_o), .trig_ovf_o(trig_ovf_o),
        .dig_timeout_o(dig_timeout_o), .clr_err_i(clr_err_i)
    );

    // Short-timeout copy sharing the same stimulus.
    lab_buffer_scheduler #(.DIG_TIMEOUT(8)) dut_t (
        .clk_i(clk_i), .nrst_i(nrst_i), .trig_i(trig_i), .trig_buf_i(trig_buf_i),
        .trig_id_i(trig_id_i), .dig_req_i(dig_req_i), .dig_start_o(t_dig_start),
        .dig_done_i(dig_done_i), .dig_busy_o(t_dig_busy), .rd_valid_o(t_rd_valid),
        .rd_buf_o(t_rd_buf), .rd_id_o(t_rd_id), .rd_release_i(rd_release_i),
        .buf_state_o(t_buf_state), .full_o(t_full), .trig_ovf_o(t_trig_ovf),
        .dig_timeout_o(t_dig_timeout), .clr_err_i(clr_err_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // Every start pulse must match the next expected buffer and last one cycle.
    always @(negedge clk_i) begin
        if (mon_en && dig_start_o != 4'd0) begin
            if (start_q.size() == 0) begin
                chk("unexpected_start", {60'd0, dig_start_o}, 64'd0);
            end else begin
                int b;
                b = start_q.pop_front();
                chk("start_order", {60'd0, dig_start_o}, 64'd1 << b);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        trig_i = 0; trig_buf_i = 0; trig_id_i = 0; dig_req_i = 0;
        dig_done_i = 0; rd_release_i = 0; clr_err_i = 0;
    endtask

    task automatic do_reset();
        nrst_i = 0;
        idle_inputs();
        start_q.delete();
        rd_q.delete();
        step(); step();
        nrst_i = 1;
        chk("reset_state", {dig_start_o, dig_busy_o, rd_valid_o, rd_buf_o, rd_id_o,
                            buf_state_o, full_o, trig_ovf_o, dig_timeout_o}, 64'd0);
    endtask

    task automatic trig(input logic [1:0] b, input logic [31:0] id, input bit accept);
        trig_i = 1; trig_buf_i = b; trig_id_i = id;
        if (accept) rd_q.push_back(id);
        step();
        trig_i = 0;
    endtask

    task automatic req(input logic [3:0] m);
        dig_req_i = m;
        step();
        dig_req_i = 0;
    endtask

    task automatic done();
        dig_done_i = 1;
        step();
        dig_done_i = 0;
    endtask

    task automatic wait_start();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (dig_start_o != 4'd0) seen = 1;
        end
        chk("start_seen", {63'd0, seen}, 64'd1);
    endtask

    task automatic do_release();
        logic [31:0] e;
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
        chk("rel_valid", {63'd0, rd_valid_o}, 64'd1);
        chk("rel_id", {32'd0, rd_id_o}, {32'd0, e});
        rd_release_i = 1;
        step();
        rd_release_i = 0;
    endtask

    typedef struct {
        logic        trig;
        logic [1:0]  tbuf;
        logic [31:0] tid;
        logic [3:0]  req;
        logic        done;
        logic        rel;
        logic        clr;
        int          push_start;
        logic [7:0]  e_state;
        logic        e_valid;
        logic [31:0] e_id;
        logic        e_full;
        logic        e_ovf;
        logic        e_busy;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // trig buf id req done rel clr start | state valid id full ovf busy
        tbl[0]  = '{0, 0, 0,       4'b0001, 0, 0, 0, -1, 8'h00, 0, 0,       0, 0, 0};
        tbl[1]  = '{0, 0, 0,       4'b0000, 1, 0, 0, -1, 8'h00, 0, 0,       0, 0, 0};
        tbl[2]  = '{0, 0, 0,       4'b0000, 0, 1, 0, -1, 8'h00, 0, 0,       0, 0, 0};
        tbl[3]  = '{1, 0, 32'hA0,  4'b0000, 0, 0, 0, -1, 8'h01, 0, 0,       0, 0, 0};
        tbl[4]  = '{0, 0, 0,       4'b0001, 0, 0, 0,  0, 8'h02, 0, 0,       0, 0, 0};
        tbl[5]  = '{0, 0, 0,       4'b0000, 0, 0, 0, -1, 8'h02, 0, 0,       0, 0, 1};
        tbl[6]  = '{0, 0, 0,       4'b0000, 0, 0, 0, -1, 8'h02, 0, 0,       0, 0, 1};
        tbl[7]  = '{0, 0, 0,       4'b0000, 1, 0, 0, -1, 8'h03, 1, 32'hA0,  0, 0, 0};
        tbl[8]  = '{1, 0, 32'hB0,  4'b0000, 0, 1, 0, -1, 8'h00, 0, 0,       0, 1, 0};
        tbl[9]  = '{0, 0, 0,       4'b0000, 0, 0, 1, -1, 8'h00, 0, 0,       0, 0, 0};
        tbl[10] = '{1, 0, 32'hC0,  4'b0000, 0, 0, 0, -1, 8'h01, 0, 0,       0, 0, 0};
        tbl[11] = '{1, 0, 32'hD0,  4'b0000, 0, 0, 1, -1, 8'h01, 0, 0,       0, 1, 0};
        tbl[12] = '{0, 0, 0,       4'b0000, 0, 0, 1, -1, 8'h01, 0, 0,       0, 0, 0};

        do_reset();

        // Stray inputs, single conversion, same-cycle release+trigger, sticky clear.
        foreach (tbl[i]) begin
            trig_i = tbl[i].trig; trig_buf_i = tbl[i].tbuf; trig_id_i = tbl[i].tid;
            dig_req_i = tbl[i].req; dig_done_i = tbl[i].done;
            rd_release_i = tbl[i].rel; clr_err_i = tbl[i].clr;
            if (tbl[i].push_start >= 0) start_q.push_back(tbl[i].push_start);
            step();
            idle_inputs();
            chk($sformatf("v%0d_state", i), {56'd0, buf_state_o}, {56'd0, tbl[i].e_state});
            chk($sformatf("v%0d_valid", i), {63'd0, rd_valid_o}, {63'd0, tbl[i].e_valid});
            chk($sformatf("v%0d_full", i), {63'd0, full_o}, {63'd0, tbl[i].e_full});
            chk($sformatf("v%0d_ovf", i), {63'd0, trig_ovf_o}, {63'd0, tbl[i].e_ovf});
            chk($sformatf("v%0d_busy", i), {63'd0, dig_busy_o}, {63'd0, tbl[i].e_busy});
            if (tbl[i].e_valid)
                chk($sformatf("v%0d_id", i), {32'd0, rd_id_o}, {32'd0, tbl[i].e_id});
        end

        // Single buffer: exact start latency and readout.
        do_reset();
        trig(2, 32'h5, 1);
        start_q.push_back(2);
        req(4'b0100);
        chk("t1_start_n0", {60'd0, dig_start_o}, 64'd0);
        step();
        chk("t1_start_n1", {60'd0, dig_start_o}, 64'd0);
        step();
        chk("t1_start_n2", {60'd0, dig_start_o}, 64'b0100);
        step();
        chk("t1_start_n3", {60'd0, dig_start_o}, 64'd0);
        repeat (8) step();
        done();
        chk("t1_valid", {63'd0, rd_valid_o}, 64'd1);
        chk("t1_buf", {62'd0, rd_buf_o}, 64'd2);
        do_release();
        chk("t1_free", {56'd0, buf_state_o}, 64'd0);
        chk("t1_novalid", {63'd0, rd_valid_o}, 64'd0);

        // All four buffers, round-robin order, overflow and clear.
        do_reset();
        for (int b = 0; b < 4; b++) trig(2'(b), 32'(10 + b), 1);
        chk("t2_full", {63'd0, full_o}, 64'd1);
        for (int b = 0; b < 4; b++) start_q.push_back(b);
        req(4'b1111);
        for (int b = 0; b < 4; b++) begin
            wait_start();
            step();
            done();
        end
        chk("t2_all_ready", {56'd0, buf_state_o}, 64'hFF);
        trig(1, 32'h99, 0);
        chk("t2_ovf", {63'd0, trig_ovf_o}, 64'd1);
        clr_err_i = 1; step(); clr_err_i = 0;
        chk("t2_ovf_clr", {63'd0, trig_ovf_o}, 64'd0);
        for (int b = 0; b < 4; b++) do_release();
        chk("t2_empty", {62'd0, full_o, rd_valid_o}, 64'd0);

        // Out-of-order digitization still reads out in trigger order.
        do_reset();
        trig(3, 32'h33, 1);
        trig(1, 32'h11, 1);
        start_q.push_back(1);
        req(4'b0010);
        wait_start();
        done();
        chk("t3_b1_ready", {62'd0, buf_state_o[3:2]}, 64'd3);
        chk("t3_blocked", {63'd0, rd_valid_o}, 64'd0);
        start_q.push_back(3);
        req(4'b1000);
        wait_start();
        done();
        chk("t3_head_buf", {62'd0, rd_buf_o}, 64'd3);
        do_release();
        chk("t3_next_buf", {62'd0, rd_buf_o}, 64'd1);
        do_release();
        chk("t3_free", {56'd0, buf_state_o}, 64'd0);

        // Timeout on the short-timeout instance.
        mon_en = 0;
        do_reset();
        trig(0, 32'h40, 0);
        trig(1, 32'h41, 0);
        req(4'b0011);
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 2) chk("t4_start0", {60'd0, t_dig_start}, 64'b0001);
            if (i == 9) chk("t4_pre", {61'd0, t_dig_timeout, t_buf_state[1:0]}, 64'b010);
            if (i == 10) chk("t4_post", {61'd0, t_dig_timeout, t_buf_state[1:0]}, 64'b111);
            if (i == 12) chk("t4_start1", {60'd0, t_dig_start}, 64'b0010);
        end
        clr_err_i = 1; step(); clr_err_i = 0;
        chk("t4_tmo_clr", {63'd0, t_dig_timeout}, 64'd0);
        mon_en = 1;

        // Reset during conversion, then recovery.
        do_reset();
        trig(0, 32'h77, 1);
        start_q.push_back(0);
        req(4'b0001);
        wait_start();
        step();
        nrst_i = 0;
        #1;
        chk("t6_async_rst", {dig_start_o, dig_busy_o, rd_valid_o, rd_buf_o, rd_id_o,
                             buf_state_o, full_o, trig_ovf_o, dig_timeout_o}, 64'd0);
        step(); step();
        nrst_i = 1;
        rd_q.delete();
        trig(0, 32'h78, 1);
        start_q.push_back(0);
        req(4'b0001);
        wait_start();
        done();
        do_release();

        step(); step();
        chk("starts_drained", 64'(start_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
